branch_predictor_bht: RTL

// - Parametrised decode/execute branch-control unit with a per-PC branch history table (BHT).
// - Uses N-bit saturating counters instead of a single global prediction bit.
// - Predicts conditional branches in DEC and redirects JAL in DEC.
// - Resolves conditional and JALR in EXE, issues flush/redirect on mispredict, and trains the BHT.
// - Sits between the fetch PC mux and the DEC/EXE pipeline registers; adds mispredict statistics counters.

---
 rtl/core_types_pkg.sv | 39 +++
 rtl/branch_predictor_bht_table.sv | 34 +++
 rtl/branch_predictor_bht.sv | 131 +++++++++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: branch classes, the BHT EXE-stage bundle
// and the saturating-counter update rule.
package core_types_pkg;

  localparam int BP_XLEN  = 32;
  localparam int BP_IDX_W = 6;
  localparam int BP_CTR_MAX_W = 4;

  typedef enum logic [1:0] {
    BR_NON  = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2,
    BR_COND = 2'd3
  } branch_type_t;

  typedef struct packed {
    logic                valid;
    branch_type_t        br_type;
    logic [BP_XLEN-1:0]  pc;
    logic [BP_XLEN-1:0]  target;
    logic [BP_IDX_W-1:0] idx;
    logic                pred_taken;
  } bp_exe_t;

  // bits is the live counter width; upper bits of ctr are zero
  function automatic logic [BP_CTR_MAX_W-1:0] sat_update(
    input logic [BP_CTR_MAX_W-1:0] ctr,
    input logic                    taken,
    input int unsigned             bits
  );
    logic [BP_CTR_MAX_W-1:0] top;
    top = BP_CTR_MAX_W'((32'd1 << bits) - 32'd1);
    if (taken)
      sat_update = (ctr == top) ? ctr : ctr + 1'b1;
    else
      sat_update = (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_table.sv
// Counter table: one combinational read port, one clocked
// saturating up/down update port.
module bht_table
  import core_types_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int WIDTH   = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [WIDTH-1:0] ctr_q [ENTRIES];

  assign rd_data = ctr_q[rd_idx];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= RESET_VAL;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= WIDTH'(sat_update(
        BP_CTR_MAX_W'(ctr_q[upd_idx]), upd_taken, WIDTH));
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// DEC/EXE branch control with a per-PC saturating-counter BHT,
// EXE resolution, flush/redirect generation and mispredict stats.
module branch_predictor_bht
  import core_types_pkg::*;
#(
  parameter int XLEN        = BP_XLEN,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int IDX_LSB     = 2,
  parameter int STAT_BITS   = 32
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 dec_valid,
  input  branch_type_t         dec_type,
  input  logic                 dec_is_load,
  input  logic [XLEN-1:0]      dec_pc,
  input  logic [XLEN-1:0]      dec_target,
  input  logic                 exe_cond_true,
  input  logic [XLEN-1:0]      exe_alu_target,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 flush,
  output logic                 hold,
  output logic                 pred_taken,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispredict
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  bp_exe_t             exe_q;
  bp_exe_t             exe_d;
  logic [IDX_W-1:0]    dec_idx;
  logic [CTR_BITS-1:0] dec_ctr;
  logic                exe_is_cond;
  logic                exe_is_jalr;
  logic                exe_misp;
  logic [XLEN-1:0]     exe_pc;

  assign dec_idx = dec_pc[IDX_LSB +: IDX_W];

  bht_table #(
    .ENTRIES   (BHT_ENTRIES),
    .WIDTH     (CTR_BITS),
    .RESET_VAL (CTR_INIT)
  ) u_bht (
    .Clock     (Clock),
    .nReset    (nReset),
    .rd_idx    (dec_idx),
    .rd_data   (dec_ctr),
    .upd_en    (exe_is_cond),
    .upd_idx   (IDX_W'(exe_q.idx)),
    .upd_taken (exe_cond_true)
  );

  always_comb begin
    exe_is_cond = exe_q.valid && (exe_q.br_type == BR_COND);
    exe_is_jalr = exe_q.valid && (exe_q.br_type == BR_JALR);
    exe_misp    = exe_is_jalr ||
      (exe_is_cond && (exe_q.pred_taken ^ exe_cond_true));
    if (exe_is_jalr)
      exe_pc = exe_alu_target;
    else if (exe_cond_true)
      exe_pc = XLEN'(exe_q.target);
    else
      exe_pc = XLEN'(exe_q.pc) + XLEN'(4);
  end

  // EXE redirect wins; DEC outputs only when EXE is quiet
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    flush       = 1'b0;
    hold        = 1'b0;
    pred_taken  = 1'b0;
    if (exe_misp) begin
      flush       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = exe_pc;
    end else if (dec_valid) begin
      unique case (1'b1)
        (dec_type == BR_COND): begin
          pred_taken = dec_ctr[CTR_BITS-1];
          if (dec_ctr[CTR_BITS-1]) begin
            redirect    = 1'b1;
            redirect_pc = dec_target;
            hold        = 1'b1;
          end
        end
        (dec_type == BR_JAL): begin
          redirect    = 1'b1;
          redirect_pc = dec_target;
          hold        = 1'b1;
        end
        (dec_type == BR_JALR): hold = 1'b1;
        default:               hold = dec_is_load;
      endcase
    end
  end

  always_comb begin
    exe_d            = '0;
    exe_d.valid      = dec_valid && !exe_misp;
    exe_d.br_type    = dec_type;
    exe_d.pc         = BP_XLEN'(dec_pc);
    exe_d.target     = BP_XLEN'(dec_target);
    exe_d.idx        = BP_IDX_W'(dec_idx);
    exe_d.pred_taken = pred_taken;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) exe_q <= '0;
    else         exe_q <= exe_d;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      stat_branches   <= '0;
      stat_mispredict <= '0;
    end else begin
      if ((exe_is_cond || exe_is_jalr) && !(&stat_branches))
        stat_branches <= stat_branches + 1'b1;
      if (exe_misp && !(&stat_mispredict))
        stat_mispredict <= stat_mispredict + 1'b1;
    end
  end

endmodule
